// File: rtl/mcu_ctrl_pkg.sv
// ============================================================================
// Module   : mcu_ctrl_pkg
// Purpose  : Shared opcode classes, ALU codes, PSR flag positions and states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mcu_ctrl_pkg;

    localparam logic [3:0] CLS_NOP   = 4'h0;
    localparam logic [3:0] CLS_LOAD  = 4'h1;
    localparam logic [3:0] CLS_ADD   = 4'h2;
    localparam logic [3:0] CLS_SUB   = 4'h3;
    localparam logic [3:0] CLS_AND   = 4'h4;
    localparam logic [3:0] CLS_OR    = 4'h5;
    localparam logic [3:0] CLS_XOR   = 4'h6;
    localparam logic [3:0] CLS_STORE = 4'h7;
    localparam logic [3:0] CLS_JMP   = 4'h8;
    localparam logic [3:0] CLS_JZ    = 4'h9;
    localparam logic [3:0] CLS_JC    = 4'hA;
    localparam logic [3:0] CLS_HALT  = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_XOR  = 3'd5;

    localparam int PSR_N = 3;
    localparam int PSR_Z = 2;
    localparam int PSR_C = 1;
    localparam int PSR_V = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_IMM   = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mcu_decode.sv
// ============================================================================
// Module   : mcu_decode
// Purpose  : Combinational instruction-class decoder feeding the control FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mcu_decode
    import mcu_ctrl_pkg::*;
(
    input  logic [3:0] cls_i,
    output logic [2:0] alu_code_o,
    output logic       two_byte_o,
    output logic       is_alu_o,
    output logic       is_branch_o,
    output logic       illegal_o
);

    always_comb begin
        alu_code_o  = ALU_PASS;
        two_byte_o  = 1'b0;
        is_alu_o    = 1'b0;
        is_branch_o = 1'b0;
        illegal_o   = 1'b0;
        case (cls_i)
            CLS_LOAD, CLS_STORE: two_byte_o = 1'b1;
            CLS_ADD: begin two_byte_o = 1'b1; is_alu_o = 1'b1; alu_code_o = ALU_ADD; end
            CLS_SUB: begin two_byte_o = 1'b1; is_alu_o = 1'b1; alu_code_o = ALU_SUB; end
            CLS_AND: begin two_byte_o = 1'b1; is_alu_o = 1'b1; alu_code_o = ALU_AND; end
            CLS_OR:  begin two_byte_o = 1'b1; is_alu_o = 1'b1; alu_code_o = ALU_OR;  end
            CLS_XOR: begin two_byte_o = 1'b1; is_alu_o = 1'b1; alu_code_o = ALU_XOR; end
            CLS_JMP, CLS_JZ, CLS_JC: begin
                two_byte_o  = 1'b1;
                is_branch_o = 1'b1;
            end
            CLS_NOP, CLS_HALT: ;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mcu_ctrl.sv
// ============================================================================
// Module   : mcu_ctrl
// Purpose  : Mealy control FSM sequencing fetch/immediate/execute/halt phases.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mcu_ctrl
    import mcu_ctrl_pkg::*;
#(
    parameter int INST_WIDTH  = 8,
    parameter int APSR_WIDTH  = 4,
    parameter int ALUOP_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_WIDTH-1:0]  opcode,
    input  logic [APSR_WIDTH-1:0]  psr,
    input  logic                   imem_ready,
    input  logic                   dmem_ready,
    input  logic                   resume,
    output logic                   imem_req,
    output logic                   dmem_req,
    output logic                   opcode_update,
    output logic                   imm_update,
    output logic                   acc_update,
    output logic                   psr_update,
    output logic [ALUOP_WIDTH-1:0] alu_operation,
    output logic                   pc_count,
    output logic                   pc_load,
    output logic                   ram_write,
    output logic                   halted,
    output logic                   illegal
);

    state_e     state_q, state_d;
    logic [3:0] w_cls;
    logic [2:0] w_alu_code;
    logic       w_two_byte, w_is_alu, w_is_branch, w_illegal;
    logic       unused_ok;

    assign w_cls     = opcode[INST_WIDTH-1 -: 4];
    assign unused_ok = ^{opcode, psr};

    mcu_decode u_decode (
        .cls_i       (w_cls),
        .alu_code_o  (w_alu_code),
        .two_byte_o  (w_two_byte),
        .is_alu_o    (w_is_alu),
        .is_branch_o (w_is_branch),
        .illegal_o   (w_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        opcode_update = 1'b0;
        imm_update    = 1'b0;
        acc_update    = 1'b0;
        psr_update    = 1'b0;
        alu_operation = ALUOP_WIDTH'(ALU_PASS);
        pc_count      = 1'b0;
        pc_load       = 1'b0;
        ram_write     = 1'b0;
        halted        = 1'b0;
        illegal       = 1'b0;
        // Outputs are forced quiet while reset is held, even though FETCH is active.
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        opcode_update = 1'b1;
                        pc_count      = 1'b1;
                        state_d       = ST_IMM;
                    end
                end
                ST_IMM: begin
                    if (w_cls == CLS_NOP) begin
                        state_d = ST_FETCH;
                    end else if (w_cls == CLS_HALT) begin
                        state_d = ST_HALT;
                    end else if (w_illegal || !w_two_byte) begin
                        illegal = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        imem_req = 1'b1;
                        if (imem_ready) begin
                            imm_update = 1'b1;
                            pc_count   = 1'b1;
                            state_d    = ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    state_d = ST_FETCH;
                    if (w_cls == CLS_LOAD) begin
                        acc_update = 1'b1;
                    end else if (w_is_alu) begin
                        acc_update    = 1'b1;
                        psr_update    = 1'b1;
                        alu_operation = ALUOP_WIDTH'(w_alu_code);
                    end else if (w_cls == CLS_STORE) begin
                        dmem_req  = 1'b1;
                        ram_write = 1'b1;
                        if (!dmem_ready) state_d = ST_EXEC;
                    end else if (w_is_branch) begin
                        case (w_cls)
                            CLS_JZ:  pc_load = psr[PSR_Z];
                            CLS_JC:  pc_load = psr[PSR_C];
                            default: pc_load = 1'b1;
                        endcase
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                    if (resume) state_d = ST_FETCH;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mcu_ctrl.sv
// ============================================================================
// Module   : tb_mcu_ctrl
// Purpose  : Randomized self-checking bench for mcu_ctrl with a per-instruction
//            expected-cycle reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mcu_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] opcode = 8'h00;
    logic [3:0] psr = 4'h0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       resume = 1'b0;
    logic       imem_req, dmem_req, opcode_update, imm_update, acc_update, psr_update;
    logic [2:0] alu_operation;
    logic       pc_count, pc_load, ram_write, halted, illegal;

    mcu_ctrl #(.INST_WIDTH(8), .APSR_WIDTH(4), .ALUOP_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .psr(psr),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .resume(resume),
        .imem_req(imem_req), .dmem_req(dmem_req), .opcode_update(opcode_update),
        .imm_update(imm_update), .acc_update(acc_update), .psr_update(psr_update),
        .alu_operation(alu_operation), .pc_count(pc_count), .pc_load(pc_load),
        .ram_write(ram_write), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    localparam logic [13:0] E_IMREQ = 14'h2000;
    localparam logic [13:0] E_DMREQ = 14'h1000;
    localparam logic [13:0] E_OPUPD = 14'h0800;
    localparam logic [13:0] E_IMMUP = 14'h0400;
    localparam logic [13:0] E_ACC   = 14'h0200;
    localparam logic [13:0] E_PSRU  = 14'h0100;
    localparam logic [13:0] E_PCCNT = 14'h0010;
    localparam logic [13:0] E_PCLD  = 14'h0008;
    localparam logic [13:0] E_RAMW  = 14'h0004;
    localparam logic [13:0] E_HALT  = 14'h0002;
    localparam logic [13:0] E_ILL   = 14'h0001;

    wire [13:0] obs = {imem_req, dmem_req, opcode_update, imm_update, acc_update,
                       psr_update, alu_operation, pc_count, pc_load, ram_write,
                       halted, illegal};

    int    n_vec = 0;
    int    n_bad = 0;
    string cur_tag = "init";

    task automatic chk(input string tag, input logic [13:0] o, input logic [13:0] e);
        n_vec++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, o, e);
        end
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [3:0]  p;
        logic        imr;
        logic        dmr;
        logic        res;
        logic [13:0] e;
    } cyc_t;

    cyc_t       q[$];
    logic [7:0] m_op;
    logic [3:0] m_p;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic imr, input logic dmr, input logic res, input logic [13:0] e);
        cyc_t c;
        c.op = m_op; c.p = m_p; c.imr = imr; c.dmr = dmr; c.res = res; c.e = e;
        q.push_back(c);
    endtask

    task automatic drain();
        cyc_t c;
        while (q.size() > 0) begin
            @(negedge clk);
            c = q.pop_front();
            opcode = c.op; psr = c.p;
            imem_ready = c.imr; dmem_ready = c.dmr; resume = c.res;
            #2;
            chk(cur_tag, obs, c.e);
        end
    endtask

    // One instruction as a list of expected cycles: fetch stalls, fetch, then
    // class-dependent immediate/execute/halt cycles.
    task automatic build(input logic [7:0] op, input logic [3:0] p,
                         input int fs, input int ist, input int ds, input int hh);
        logic [3:0] cls;
        cls  = op[7:4];
        m_op = op; m_p = p;
        for (int i = 0; i < fs; i++) push(1'b0, rb(), rb(), E_IMREQ);
        push(1'b1, rb(), rb(), E_IMREQ | E_OPUPD | E_PCCNT);
        if (cls == 4'h0) begin
            push(rb(), rb(), rb(), 14'h0);
        end else if (cls == 4'hF) begin
            push(rb(), rb(), rb(), 14'h0);
            for (int i = 0; i < hh; i++) push(rb(), rb(), 1'b0, E_HALT);
            push(rb(), rb(), 1'b1, E_HALT);
        end else if (cls >= 4'hB) begin
            push(rb(), rb(), rb(), E_ILL);
        end else begin
            for (int i = 0; i < ist; i++) push(1'b0, rb(), rb(), E_IMREQ);
            push(1'b1, rb(), rb(), E_IMREQ | E_IMMUP | E_PCCNT);
            if (cls == 4'h1) begin
                push(rb(), rb(), rb(), E_ACC);
            end else if (cls <= 4'h6) begin
                push(rb(), rb(), rb(), E_ACC | E_PSRU | ((14'(cls) - 14'd1) << 5));
            end else if (cls == 4'h7) begin
                for (int i = 0; i < ds; i++) push(rb(), 1'b0, rb(), E_DMREQ | E_RAMW);
                push(rb(), 1'b1, rb(), E_DMREQ | E_RAMW);
            end else if (cls == 4'h8) begin
                push(rb(), rb(), rb(), E_PCLD);
            end else if (cls == 4'h9) begin
                push(rb(), rb(), rb(), p[2] ? E_PCLD : 14'h0);
            end else begin
                push(rb(), rb(), rb(), p[1] ? E_PCLD : 14'h0);
            end
        end
    endtask

    task automatic run_instr(input string tag, input logic [7:0] op, input logic [3:0] p,
                             input int fs, input int ist, input int ds, input int hh);
        cur_tag = tag;
        build(op, p, fs, ist, ds, hh);
        drain();
    endtask

    initial begin
        opcode = 8'h10; imem_ready = 1'b1;
        #3;
        chk("reset_hold", obs, 14'h0);
        @(negedge clk);
        rst = 1'b0; imem_ready = 1'b0;
        #2;
        chk("reset_release", obs, E_IMREQ);

        run_instr("load_10", 8'h10, 4'h0, 0, 0, 0, 0);
        run_instr("add_istall2", 8'h20, 4'h0, 0, 2, 0, 0);
        run_instr("jz_taken", 8'h90, 4'b0100, 0, 0, 0, 0);
        run_instr("jz_not_taken", 8'h90, 4'b0000, 0, 0, 0, 0);
        run_instr("jc_taken", 8'hA3, 4'b0010, 1, 0, 0, 0);
        run_instr("store_ds3", 8'h70, 4'h0, 0, 0, 3, 0);
        run_instr("halt5", 8'hF0, 4'h0, 0, 0, 0, 5);
        run_instr("illegal_b0", 8'hB0, 4'h0, 0, 0, 0, 0);
        run_instr("nop_00", 8'h0C, 4'h0, 2, 0, 0, 0);

        // Reset during a STORE stall abandons the store.
        cur_tag = "store_pre_rst";
        m_op = 8'h70; m_p = 4'h0;
        push(1'b1, 1'b0, 1'b0, E_IMREQ | E_OPUPD | E_PCCNT);
        push(1'b1, 1'b0, 1'b0, E_IMREQ | E_IMMUP | E_PCCNT);
        push(1'b0, 1'b0, 1'b0, E_DMREQ | E_RAMW);
        drain();
        @(negedge clk);
        dmem_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_store", obs, 14'h0);
        @(negedge clk);
        #1;
        chk("rst_held", obs, 14'h0);
        rst = 1'b0; imem_ready = 1'b0;
        #1;
        chk("rst_release_fetch", obs, E_IMREQ);

        for (int k = 0; k < 300; k++) begin
            run_instr("random",
                      {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))},
                      4'($urandom_range(0, 15)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mcu_ctrl.md
MCU_CTRL -- requirements
Module: mcu_ctrl

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 8, instruction/opcode width (min 4).
REQ-002 SHALL have parameter APSR_WIDTH, default 4, PSR width; flag positions N=3, Z=2, C=1, V=0.
REQ-003 SHALL have parameter ALUOP_WIDTH, default 3, ALU selector width.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rst  in  1  asynchronous reset, active-high.
REQ-007 opcode  in  INST_WIDTH  registered current instruction.
REQ-008 psr  in  APSR_WIDTH  registered program status.
REQ-009 imem_ready  in  1  instruction memory data valid this cycle.
REQ-010 dmem_ready  in  1  data memory write accepted this cycle.
REQ-011 resume  in  1  leave HALT.
REQ-012 imem_req, dmem_req  out  1 each  memory request.
REQ-013 opcode_update, imm_update, acc_update, psr_update  out  1 each  register load strobes.
REQ-014 alu_operation  out  ALUOP_WIDTH  ALU selector.
REQ-015 pc_count, pc_load  out  1 each  PC increment / PC load from IMM.
REQ-016 ram_write  out  1  data memory write strobe.
REQ-017 halted  out  1  high in HALT; illegal  out  1  one-cycle pulse on undefined opcode.

Function
REQ-018 Decode SHALL use class = opcode[INST_WIDTH-1 -: 4]; lower bits ignored.
REQ-019 Classes: 0 NOP, 1 LOAD, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 STORE, 8 JMP, 9 JZ, A JC, F HALT; B-E illegal.
REQ-020 ALU codes: PASS=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5; alu_operation SHALL be PASS whenever not in EXEC with an ALU class.
REQ-021 States SHALL be FETCH, IMM, EXEC, HALT; FETCH after reset.
REQ-022 FETCH: imem_req=1; when imem_ready, opcode_update=1, pc_count=1, next IMM; else stay (stall, all strobes 0).
REQ-023 IMM: NOP -> FETCH; HALT -> HALT; illegal -> illegal=1, FETCH; otherwise imem_req=1, on imem_ready imm_update=1, pc_count=1, next EXEC, else stay.
REQ-024 EXEC LOAD: acc_update=1, alu_operation=PASS, psr_update=0; next FETCH.
REQ-025 EXEC ADD/SUB/AND/OR/XOR: acc_update=1, psr_update=1, matching ALU code; next FETCH.
REQ-026 EXEC STORE: dmem_req=1, ram_write=1 held until dmem_ready; next FETCH on dmem_ready cycle; acc/psr untouched.
REQ-027 EXEC JMP: pc_load=1; JZ: pc_load=psr[2]; JC: pc_load=psr[1]; one cycle; next FETCH.
REQ-028 pc_count and pc_load SHALL never assert in the same cycle.
REQ-029 HALT: halted=1, all strobes 0; resume=1 -> FETCH next cycle; resume ignored outside HALT.
REQ-030 Latency: zero-wait NOP/HALT 2 cycles, two-byte instructions 3 cycles; each ready-low cycle adds one.
REQ-031 All outputs SHALL be combinational from state and inputs (Mealy); state register only sequential element.

Reset
REQ-032 rst=1 SHALL force state FETCH asynchronously; while asserted all outputs 0, alu_operation=PASS, halted=0.
REQ-033 Reset mid-instruction (including STORE stall) SHALL abandon it; no strobe emitted on rst-deassert cycle edge; FETCH resumes on first edge after deassert.

Structure
REQ-034 Opcode classes, ALU codes, PSR flag positions, state encoding SHALL live in shared defs.v package/include.
REQ-035 One sub-module natural: mcu_decode (combinational class -> ALU code, two_byte, is_branch, illegal flags).
REQ-036 Target 150-300 lines RTL; single state register, no datapath.

Verification
REQ-037 Zero-wait LOAD 0x10/0xAE -> cycles: opcode_update+pc_count, imm_update+pc_count, acc_update alu=PASS; back to FETCH on cycle 4.
REQ-038 ADD 0x20 with imem_ready low 2 cycles in IMM -> imm_update delayed 2 cycles, then acc_update=psr_update=1, alu=1.
REQ-039 JZ 0x90 with psr=4'b0100 -> pc_load=1 in EXEC; psr=4'b0000 -> pc_load=0; pc_count never coincident.
REQ-040 STORE 0x70, dmem_ready low 3 cycles -> ram_write=dmem_req=1 for 4 cycles, then FETCH.
REQ-041 HALT 0xF0 -> halted=1 holds 5 cycles; resume pulse -> FETCH, imem_req=1 next cycle; illegal 0xB0 -> illegal pulse, no imm fetch.
REQ-042 rst asserted during STORE stall -> outputs 0 immediately; after release first cycle is FETCH with imem_req=1.
